// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared arbiter state, owner ids and hex-to-segment table
package seg_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_OWN_A = 2'd1,
        ARB_OWN_B = 2'd2
    } arb_state_e;

    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

    // gfedcba, active-high; consumed by the combinational decoder after this block
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        return HEX_SEG[nib];
    endfunction

endpackage

// File: rtl/seg_scan_arbiter_if.sv
// rtl/seg_scan_arbiter_if.sv - requester, grant and scan-output bundle
interface seg_scan_arbiter_if #(
    parameter int DIGITS = 4
);
    logic                  req_a_i;
    logic                  req_b_i;
    logic [4*DIGITS-1:0]   data_a_i;
    logic [4*DIGITS-1:0]   data_b_i;
    logic [DIGITS-1:0]     dp_a_i;
    logic [DIGITS-1:0]     dp_b_i;
    logic                  gnt_a_o;
    logic                  gnt_b_o;
    logic [DIGITS-1:0]     seg_cs_o;
    logic [3:0]            nibble_o;
    logic                  dp_o;
    logic                  frame_done_o;

    modport slave (
        input  req_a_i, req_b_i, data_a_i, data_b_i, dp_a_i, dp_b_i,
        output gnt_a_o, gnt_b_o, seg_cs_o, nibble_o, dp_o, frame_done_o
    );

    modport master (
        output req_a_i, req_b_i, data_a_i, data_b_i, dp_a_i, dp_b_i,
        input  gnt_a_o, gnt_b_o, seg_cs_o, nibble_o, dp_o, frame_done_o
    );
endinterface

// File: rtl/scan_tick_gen.sv
// rtl/scan_tick_gen.sv - digit-rate tick and per-slot dead-time flag
// SEG_BLANK_EN enables the BLANK_CYC dead-time window; otherwise blank_o stays low.
module scan_tick_gen #(
    parameter int TICK_DIV  = 10,
    parameter int BLANK_CYC = 3
) (
    input  logic clk_i,
    input  logic rst_n_i,
    output logic tick_o,
    output logic blank_o
);
`ifdef SEG_BLANK_EN
    localparam int BLANK_LEN = BLANK_CYC;
`else
    localparam int BLANK_LEN = BLANK_CYC * 0;
`endif
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          r_blank;
    logic          w_tick;

    assign w_tick  = (r_cnt == CW'(TICK_DIV - 1));
    assign tick_o  = w_tick;
    assign blank_o = r_blank;

    // The window opens on the tick edge and covers count values 0..BLANK_LEN-1
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt   <= '0;
            r_blank <= 1'b0;
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
            if (w_tick)
                r_blank <= (BLANK_LEN != 0);
            else if (r_cnt == CW'(BLANK_LEN - 1))
                r_blank <= 1'b0;
        end
    end
endmodule

// File: rtl/seg_scan_arbiter.sv
// rtl/seg_scan_arbiter.sv - round-robin display arbiter and 7-seg digit scanner
// Optional anti-ghosting dead time via SEG_BLANK_EN (implemented in scan_tick_gen).
module seg_scan_arbiter
    import seg_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int SCAN_HZ     = 1000,
    parameter int DIGITS      = 4,
    parameter int HOLD_FRAMES = 250,
    parameter int BLANK_CYC   = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    seg_scan_arbiter_if.slave bus
);
    localparam int TICK_DIV = CLK_HZ / SCAN_HZ;
    localparam int IW       = $clog2(DIGITS);
    localparam int HW       = $clog2(HOLD_FRAMES + 1);

    localparam logic [1:0] S_IDLE  = ARB_IDLE;
    localparam logic [1:0] S_OWN_A = ARB_OWN_A;
    localparam logic [1:0] S_OWN_B = ARB_OWN_B;

    logic              w_tick, w_blank, w_bound, w_dp;
    logic [IW-1:0]     w_idx_nxt;
    logic [HW-1:0]     w_hold_inc;
    logic [1:0]        w_state_nxt;
    logic [4*DIGITS-1:0] w_data;
    logic [DIGITS-1:0] w_dps;
    logic [3:0]        w_nib;

    logic [1:0]        r_state;
    logic              r_last;
    logic [IW-1:0]     r_idx;
    logic [HW-1:0]     r_hold;
    logic [DIGITS-1:0] r_cs;
    logic [3:0]        r_nib;
    logic              r_dp, r_fd;

    scan_tick_gen #(
        .TICK_DIV  (TICK_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_tick (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .tick_o  (w_tick),
        .blank_o (w_blank)
    );

    assign w_bound    = w_tick && (r_idx == IW'(DIGITS - 1));
    assign w_idx_nxt  = w_bound ? '0 : r_idx + IW'(1);
    assign w_hold_inc = (r_hold == HW'(HOLD_FRAMES)) ? r_hold : r_hold + HW'(1);

    // Hold is judged on the frame count including the frame ending now,
    // so an owner under contention keeps exactly HOLD_FRAMES full frames.
    always_comb begin
        w_state_nxt = r_state;
        if (w_bound) begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_a_i && bus.req_b_i)
                        w_state_nxt = (r_last == OWNER_B) ? S_OWN_A : S_OWN_B;
                    else if (bus.req_a_i)
                        w_state_nxt = S_OWN_A;
                    else if (bus.req_b_i)
                        w_state_nxt = S_OWN_B;
                end
                S_OWN_A: begin
                    if (bus.req_b_i && (w_hold_inc >= HW'(HOLD_FRAMES) || !bus.req_a_i))
                        w_state_nxt = S_OWN_B;
                    else if (!bus.req_a_i && !bus.req_b_i)
                        w_state_nxt = S_IDLE;
                end
                S_OWN_B: begin
                    if (bus.req_a_i && (w_hold_inc >= HW'(HOLD_FRAMES) || !bus.req_b_i))
                        w_state_nxt = S_OWN_A;
                    else if (!bus.req_a_i && !bus.req_b_i)
                        w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign w_data = (w_state_nxt == S_OWN_B) ? bus.data_b_i : bus.data_a_i;
    assign w_dps  = (w_state_nxt == S_OWN_B) ? bus.dp_b_i   : bus.dp_a_i;

    always_comb begin
        w_nib = '0;
        w_dp  = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (w_idx_nxt == IW'(d)) begin
                w_nib = w_data[4*d +: 4];
                w_dp  = w_dps[d];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
            r_last  <= OWNER_B;
            r_idx   <= '0;
            r_hold  <= '0;
            r_cs    <= '0;
            r_nib   <= '0;
            r_dp    <= 1'b0;
            r_fd    <= 1'b0;
        end else begin
            r_fd <= w_bound;
            if (w_tick) begin
                r_idx <= w_idx_nxt;
                if (w_state_nxt == S_IDLE) begin
                    r_cs  <= '0;
                    r_nib <= '0;
                    r_dp  <= 1'b0;
                end else begin
                    r_cs  <= DIGITS'(1) << w_idx_nxt;
                    r_nib <= w_nib;
                    r_dp  <= w_dp;
                end
            end
            if (w_bound) begin
                r_state <= w_state_nxt;
                if (w_state_nxt != r_state)
                    r_hold <= '0;
                else if (r_state != S_IDLE)
                    r_hold <= w_hold_inc;
                if (w_state_nxt == S_OWN_A)
                    r_last <= OWNER_A;
                else if (w_state_nxt == S_OWN_B)
                    r_last <= OWNER_B;
            end
        end
    end

    assign bus.gnt_a_o      = (r_state == S_OWN_A);
    assign bus.gnt_b_o      = (r_state == S_OWN_B);
    assign bus.seg_cs_o     = r_cs & {DIGITS{~w_blank}};
    assign bus.nibble_o     = r_nib;
    assign bus.dp_o         = r_dp;
    assign bus.frame_done_o = r_fd;
endmodule

// File: tb/tb_seg_scan_arbiter.sv
// tb/tb_seg_scan_arbiter.sv - directed vector bench for seg_scan_arbiter
module tb_seg_scan_arbiter;
`ifdef SEG_BLANK_EN
    localparam bit BLANK_ON = 1'b1;
`else
    localparam bit BLANK_ON = 1'b0;
`endif

    typedef struct {
        int         k;
        logic       ra, rb;
        logic [15:0] da;
        logic       ga, gb;
        logic [3:0] cs, nib;
        logic       dp, fd;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seg_scan_arbiter_if #(.DIGITS(4)) bus();

    seg_scan_arbiter #(
        .CLK_HZ(1000), .SCAN_HZ(100), .DIGITS(4), .HOLD_FRAMES(2), .BLANK_CYC(3)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    int   n_chk  = 0;
    int   n_fail = 0;
    int   k_now  = 0;
    vec_t vecs[22];

    function automatic vec_t mk(int k, logic ra, logic rb, logic [15:0] da, logic ga, logic gb,
                                logic [3:0] cs, logic [3:0] nib, logic dp, logic fd);
        vec_t v;
        v.k = k; v.ra = ra; v.rb = rb; v.da = da; v.ga = ga; v.gb = gb;
        v.cs = cs; v.nib = nib; v.dp = dp; v.fd = fd;
        return v;
    endfunction

    function automatic logic [3:0] vis(int k, logic [3:0] cs);
        return (BLANK_ON && ((k % 10) < 3)) ? 4'h0 : cs;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic ga, input logic gb, input logic [3:0] cs,
                              input logic [3:0] nib, input logic dp, input logic fd);
        chk({tag, "_gnt_a"}, 32'(bus.gnt_a_o), 32'(ga));
        chk({tag, "_gnt_b"}, 32'(bus.gnt_b_o), 32'(gb));
        chk({tag, "_cs"},    32'(bus.seg_cs_o), 32'(cs));
        chk({tag, "_nib"},   32'(bus.nibble_o), 32'(nib));
        chk({tag, "_dp"},    32'(bus.dp_o), 32'(dp));
        chk({tag, "_fd"},    32'(bus.frame_done_o), 32'(fd));
    endtask

    task automatic adv_to(input int k);
        while (k_now < k) begin
            @(negedge clk);
            k_now++;
        end
    endtask

    task automatic restart(input logic ra, input logic rb, input logic [15:0] da, input logic [15:0] db);
        rst_n = 1'b0;
        bus.req_a_i  = ra;
        bus.req_b_i  = rb;
        bus.data_a_i = da;
        bus.data_b_i = db;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        k_now = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.dp_a_i = 4'b0100;
        bus.dp_b_i = 4'b0001;

        vecs[0]  = mk(0,   1'b1, 1'b0, 16'h4321, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        vecs[1]  = mk(9,   1'b1, 1'b0, 16'h4321, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        vecs[2]  = mk(39,  1'b1, 1'b0, 16'h4321, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        vecs[3]  = mk(40,  1'b1, 1'b0, 16'h4321, 1'b1, 1'b0, 4'h1, 4'h1, 1'b0, 1'b1);
        vecs[4]  = mk(41,  1'b1, 1'b0, 16'h4321, 1'b1, 1'b0, 4'h1, 4'h1, 1'b0, 1'b0);
        vecs[5]  = mk(45,  1'b1, 1'b0, 16'h4391, 1'b1, 1'b0, 4'h1, 4'h1, 1'b0, 1'b0);
        vecs[6]  = mk(50,  1'b1, 1'b0, 16'h4391, 1'b1, 1'b0, 4'h2, 4'h9, 1'b0, 1'b0);
        vecs[7]  = mk(55,  1'b1, 1'b0, 16'h4321, 1'b1, 1'b0, 4'h2, 4'h9, 1'b0, 1'b0);
        vecs[8]  = mk(60,  1'b1, 1'b0, 16'h4321, 1'b1, 1'b0, 4'h4, 4'h3, 1'b1, 1'b0);
        vecs[9]  = mk(70,  1'b1, 1'b0, 16'h4321, 1'b1, 1'b0, 4'h8, 4'h4, 1'b0, 1'b0);
        vecs[10] = mk(80,  1'b1, 1'b0, 16'h4321, 1'b1, 1'b0, 4'h1, 4'h1, 1'b0, 1'b1);
        vecs[11] = mk(81,  1'b1, 1'b0, 16'h4321, 1'b1, 1'b0, 4'h1, 4'h1, 1'b0, 1'b0);
        vecs[12] = mk(95,  1'b0, 1'b0, 16'h4321, 1'b1, 1'b0, 4'h2, 4'h2, 1'b0, 1'b0);
        vecs[13] = mk(100, 1'b0, 1'b0, 16'h4321, 1'b1, 1'b0, 4'h4, 4'h3, 1'b1, 1'b0);
        vecs[14] = mk(110, 1'b0, 1'b0, 16'h4321, 1'b1, 1'b0, 4'h8, 4'h4, 1'b0, 1'b0);
        vecs[15] = mk(119, 1'b0, 1'b0, 16'h4321, 1'b1, 1'b0, 4'h8, 4'h4, 1'b0, 1'b0);
        vecs[16] = mk(120, 1'b0, 1'b0, 16'h4321, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
        vecs[17] = mk(130, 1'b0, 1'b0, 16'h4321, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        vecs[18] = mk(135, 1'b0, 1'b1, 16'h4321, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        vecs[19] = mk(159, 1'b0, 1'b1, 16'h4321, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        vecs[20] = mk(160, 1'b0, 1'b1, 16'h4321, 1'b0, 1'b1, 4'h1, 4'h5, 1'b1, 1'b1);
        vecs[21] = mk(170, 1'b0, 1'b1, 16'h4321, 1'b0, 1'b1, 4'h2, 4'h6, 1'b0, 1'b0);

        // single requester, mid-slot data change, owner release, then B alone
        restart(1'b1, 1'b0, 16'h4321, 16'h8765);
        for (int i = 0; i < 22; i++) begin
            adv_to(vecs[i].k);
            bus.req_a_i  = vecs[i].ra;
            bus.req_b_i  = vecs[i].rb;
            bus.data_a_i = vecs[i].da;
            check_outs($sformatf("tbl%0d_k%0d", i, vecs[i].k), vecs[i].ga, vecs[i].gb,
                       vis(vecs[i].k, vecs[i].cs), vecs[i].nib, vecs[i].dp, vecs[i].fd);
        end

        // contention from reset: A first, B after two full frames, A two frames later
        restart(1'b1, 1'b1, 16'h4321, 16'h8765);
        adv_to(40);  check_outs("cont_k40",  1'b1, 1'b0, vis(40, 4'h1), 4'h1, 1'b0, 1'b1);
        adv_to(80);  check_outs("cont_k80",  1'b1, 1'b0, vis(80, 4'h1), 4'h1, 1'b0, 1'b1);
        adv_to(119); check_outs("cont_k119", 1'b1, 1'b0, 4'h8, 4'h4, 1'b0, 1'b0);
        for (int j = 0; j < 10; j++) begin
            adv_to(120 + j);
            check_outs($sformatf("cont_slot_k%0d", 120 + j), 1'b0, 1'b1, vis(120 + j, 4'h1),
                       4'h5, 1'b1, (j == 0));
        end
        adv_to(160); check_outs("cont_k160", 1'b0, 1'b1, vis(160, 4'h1), 4'h5, 1'b1, 1'b1);
        adv_to(199); check_outs("cont_k199", 1'b0, 1'b1, 4'h8, 4'h8, 1'b0, 1'b0);
        adv_to(200); check_outs("cont_k200", 1'b1, 1'b0, vis(200, 4'h1), 4'h1, 1'b0, 1'b1);

        // early handover: A drops while B requests, B wins before the hold expires
        restart(1'b1, 1'b0, 16'h4321, 16'h8765);
        adv_to(40);  check_outs("early_k40", 1'b1, 1'b0, vis(40, 4'h1), 4'h1, 1'b0, 1'b1);
        adv_to(50);
        bus.req_a_i = 1'b0;
        bus.req_b_i = 1'b1;
        check_outs("early_k50", 1'b1, 1'b0, vis(50, 4'h2), 4'h2, 1'b0, 1'b0);
        adv_to(79);  check_outs("early_k79", 1'b1, 1'b0, 4'h8, 4'h4, 1'b0, 1'b0);
        adv_to(80);  check_outs("early_k80", 1'b0, 1'b1, vis(80, 4'h1), 4'h5, 1'b1, 1'b1);

        // asynchronous reset mid-slot, then restart timing from index 0
        adv_to(85);  check_outs("arst_pre", 1'b0, 1'b1, 4'h1, 4'h5, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        check_outs("arst_now", 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        restart(1'b0, 1'b1, 16'h4321, 16'h8765);
        adv_to(39);  check_outs("arst_k39", 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        adv_to(40);  check_outs("arst_k40", 1'b0, 1'b1, vis(40, 4'h1), 4'h5, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
